operand_fetch_stage: RTL and testbench

//  Decode-to-execute stage wrapped around regfile. Drives rs1/rs2 read addresses.

---
 rtl/rv_pkg.sv | 23 ++
 rtl/operand_fetch_stage_if.sv | 35 +++
 rtl/reg_scoreboard.sv | 48 ++++
 rtl/operand_fetch_stage.sv | 149 ++++++++++++++
 tb/tb_operand_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared constants and helpers for the operand fetch stage.
// Optional build macro used by operand_fetch_stage: OPERAND_BYPASS_EN.
package rv_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    // Bit positions of the register fields inside a raw 32-bit instruction
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

    typedef logic [REG_AW-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // Extract a 5-bit register index starting at lsb
    function automatic reg_addr_t reg_field(input logic [31:0] instr, input int unsigned lsb);
        return instr[lsb +: REG_AW];
    endfunction

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Decoder-side and execute-side handshake bundle of the operand fetch stage.
// The stage itself connects through the slave modport; its environment uses master.
interface operand_fetch_stage_if #(
    parameter int XLEN = rv_pkg::XLEN
);
    // Upstream (decoder -> stage)
    logic            i_valid;
    logic            o_ready;
    logic [XLEN-1:0] i_pc;
    logic [31:0]     i_instr;
    logic            i_uses_rs1;
    logic            i_uses_rs2;
    logic            i_writes_rd;

    // Downstream (stage -> execute)
    logic            o_valid;
    logic            i_ready;
    logic [XLEN-1:0] o_pc;
    logic [31:0]     o_instr;
    logic [XLEN-1:0] o_rs1_data;
    logic [XLEN-1:0] o_rs2_data;
    logic [4:0]      o_rd_addr;
    logic            o_rd_wren;

    modport slave (
        input  i_valid, i_pc, i_instr, i_uses_rs1, i_uses_rs2, i_writes_rd, i_ready,
        output o_ready, o_valid, o_pc, o_instr, o_rs1_data, o_rs2_data, o_rd_addr, o_rd_wren
    );

    modport master (
        output i_valid, i_pc, i_instr, i_uses_rs1, i_uses_rs2, i_writes_rd, i_ready,
        input  o_ready, o_valid, o_pc, o_instr, o_rs1_data, o_rs2_data, o_rd_addr, o_rd_wren
    );

endinterface

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard for the 32 architectural registers.
// Priority per index: flush-clear > set > writeback-clear; x0 is never busy.
module reg_scoreboard
    import rv_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_set_en,
    input  reg_addr_t           i_set_addr,
    input  logic                i_clr_en,
    input  reg_addr_t           i_clr_addr,
    input  logic                i_flush_clr_en,
    input  reg_addr_t           i_flush_clr_addr,
    output logic [NUM_REGS-1:0] o_busy
);

    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] busy_q;

    // Next busy vector: later assignments override earlier ones, encoding the priority order
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        busy_d = busy_q;
        if (i_clr_en) begin
            busy_d[i_clr_addr] = 1'b0;
        end
        if (i_set_en) begin
            busy_d[i_set_addr] = 1'b1;
        end
        if (i_flush_clr_en) begin
            busy_d[i_flush_clr_addr] = 1'b0;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    // Busy register with synchronous reset
    always_ff @(posedge i_clk) begin
        // NOTE: the busy vector is a flop bank (not a RAM), so it is reset; state uses <= only.
        if (i_reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute operand fetch stage: regfile read addressing, RAW/WAW
// hazard stall via a busy scoreboard, writeback snooping and the ID/EX register.
// Build macro: OPERAND_BYPASS_EN forwards a same-cycle writeback into the
// operand capture instead of stalling one extra cycle.
module operand_fetch_stage
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
)
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    operand_fetch_stage_if.slave  bus,
    output reg_addr_t             o_rs1_addr,
    output reg_addr_t             o_rs2_addr,
    input  logic [XLEN-1:0]       i_rs1_data,
    input  logic [XLEN-1:0]       i_rs2_data,
    input  reg_addr_t             i_wb_rd_addr,
    input  logic [XLEN-1:0]       i_wb_rd_data,
    input  logic                  i_wb_rd_wren,
    input  logic                  i_flush
);

    reg_addr_t           rs1;
    reg_addr_t           rs2;
    reg_addr_t           rd;
    logic [NUM_REGS-1:0] busy;

    logic byp_rs1;
    logic byp_rs2;
    logic hz_rs1;
    logic hz_rs2;
    logic waw;
    logic slot_free;
    logic ready;
    logic capture;
    logic dequeue;
    logic rd_wren_new;

    logic [XLEN-1:0] rs1_op;
    logic [XLEN-1:0] rs2_op;

    // ID/EX register
    logic            valid_d,    valid_q;
    logic [XLEN-1:0] pc_d,       pc_q;
    logic [31:0]     instr_d,    instr_q;
    logic [XLEN-1:0] rs1_data_d, rs1_data_q;
    logic [XLEN-1:0] rs2_data_d, rs2_data_q;
    reg_addr_t       rd_addr_d,  rd_addr_q;
    logic            rd_wren_d,  rd_wren_q;

    assign rs1 = reg_field(bus.i_instr, RS1_LSB);
    assign rs2 = reg_field(bus.i_instr, RS2_LSB);
    assign rd  = reg_field(bus.i_instr, RD_LSB);

    assign o_rs1_addr = rs1;
    assign o_rs2_addr = rs2;

`ifdef OPERAND_BYPASS_EN
    assign byp_rs1 = i_wb_rd_wren && (i_wb_rd_addr == rs1) && (rs1 != REG_ZERO);
    assign byp_rs2 = i_wb_rd_wren && (i_wb_rd_addr == rs2) && (rs2 != REG_ZERO);
`else
    // Without forwarding the stage waits for the regfile to hold the written value
    assign byp_rs1 = 1'b0;
    assign byp_rs2 = 1'b0;
`endif

    assign hz_rs1 = bus.i_uses_rs1 && (rs1 != REG_ZERO) && busy[rs1] && !byp_rs1;
    assign hz_rs2 = bus.i_uses_rs2 && (rs2 != REG_ZERO) && busy[rs2] && !byp_rs2;
    assign waw    = bus.i_writes_rd && (rd != REG_ZERO) && busy[rd];

    assign slot_free = !valid_q || bus.i_ready;
    assign ready     = !i_reset && !i_flush && slot_free && !hz_rs1 && !hz_rs2 && !waw;
    assign capture   = bus.i_valid && ready;
    assign dequeue   = valid_q && bus.i_ready;

    assign rd_wren_new = bus.i_writes_rd && (rd != REG_ZERO);

    assign rs1_op = byp_rs1 ? i_wb_rd_data : i_rs1_data;
    assign rs2_op = byp_rs2 ? i_wb_rd_data : i_rs2_data;

    // ID/EX next state: flush beats capture, capture beats a plain dequeue; otherwise hold
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_addr_d  = rd_addr_q;
        rd_wren_d  = rd_wren_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (capture) begin
            valid_d    = 1'b1;
            pc_d       = bus.i_pc;
            instr_d    = bus.i_instr;
            rs1_data_d = rs1_op;
            rs2_data_d = rs2_op;
            rd_addr_d  = rd;
            rd_wren_d  = rd_wren_new;
        end else if (dequeue) begin
            valid_d = 1'b0;
        end
    end

    // ID/EX register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            instr_q    <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_addr_q  <= REG_ZERO;
            rd_wren_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_wren_q  <= rd_wren_d;
        end
    end

    // A flushed instruction never writes back, so its busy bit is released here
    reg_scoreboard u_sb (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_set_en         (capture && rd_wren_new),
        .i_set_addr       (rd),
        .i_clr_en         (i_wb_rd_wren),
        .i_clr_addr       (i_wb_rd_addr),
        .i_flush_clr_en   (i_flush && valid_q && rd_wren_q),
        .i_flush_clr_addr (rd_addr_q),
        .o_busy           (busy)
    );

    assign bus.o_ready    = ready;
    assign bus.o_valid    = valid_q;
    assign bus.o_pc       = pc_q;
    assign bus.o_instr    = instr_q;
    assign bus.o_rs1_data = rs1_data_q;
    assign bus.o_rs2_data = rs2_data_q;
    assign bus.o_rd_addr  = rd_addr_q;
    assign bus.o_rd_wren  = rd_wren_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a scoreboard queue of expected
// ID/EX transactions; expectations for OPERAND_BYPASS_EN follow the same macro.
module tb_operand_fetch_stage;

    logic        i_clk;
    logic        i_reset;
    logic        i_flush;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_wren;

    logic [31:0] rf [32];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        wren;
    } exp_t;

    exp_t sb_q[$];

    operand_fetch_stage_if #(.XLEN(32)) bus ();

    operand_fetch_stage #(.XLEN(32)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .bus          (bus),
        .o_rs1_addr   (rs1_addr),
        .o_rs2_addr   (rs2_addr),
        .i_rs1_data   (rs1_data),
        .i_rs2_data   (rs2_data),
        .i_wb_rd_addr (wb_addr),
        .i_wb_rd_data (wb_data),
        .i_wb_rd_wren (wb_wren),
        .i_flush      (i_flush)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Regfile model: async read, write on posedge, x0 hard-wired to zero
    always @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
            rf[1] <= 32'd5;
            rf[2] <= 32'd7;
        end else if (wb_wren && wb_addr != 5'd0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'h00, rs2, rs1, 3'h0, rd, 7'h33};
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic u1, input logic u2, input logic wr);
        bus.i_valid     = 1'b1;
        bus.i_pc        = pc;
        bus.i_instr     = instr;
        bus.i_uses_rs1  = u1;
        bus.i_uses_rs2  = u2;
        bus.i_writes_rd = wr;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [4:0] rd, input logic wren);
        exp_t e;
        e.pc = pc; e.instr = instr; e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.wren = wren;
        sb_q.push_back(e);
    endtask

    task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
        wb_wren = en;
        wb_addr = addr;
        wb_data = data;
    endtask

    // Output monitor: a transaction leaving the stage at the next edge is compared to the queue head
    always @(negedge i_clk) begin
        if (!i_reset && !i_flush && bus.o_valid && bus.i_ready) begin
            check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_pc",    bus.o_pc,       e.pc);
                check("out_instr", bus.o_instr,    e.instr);
                check("out_rs1",   bus.o_rs1_data, e.rs1);
                check("out_rs2",   bus.o_rs2_data, e.rs2);
                check("out_rd",    bus.o_rd_addr,  e.rd);
                check("out_wren",  bus.o_rd_wren,  e.wren);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_flush = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        drive(32'h0, mk(5'd1, 5'd2, 5'd3), 1'b1, 1'b1, 1'b1);
        bus.i_ready = 1'b1;

        // Reset state; o_ready low while reset even with an offered instruction
        tick();
        tick();
        check("rst_ready", bus.o_ready, 1'b0);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_busy",  dut.busy,    32'h0);
        i_reset = 1'b0;
        bus.i_valid = 1'b0;

        // 1. ADD x3,x1,x2
        drive(32'h100, mk(5'd3, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1);
        push(32'h100, mk(5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 5'd3, 1'b1);
        #1 check("t1_ready", bus.o_ready, 1'b1);
        tick();
        check("t1_valid", bus.o_valid,    1'b1);
        check("t1_rs1",   bus.o_rs1_data, 32'd5);
        check("t1_rs2",   bus.o_rs2_data, 32'd7);
        check("t1_busy3", dut.busy[3],    1'b1);

        // 2. SUB x4,x3,x1 right behind: RAW on x3
        drive(32'h104, mk(5'd4, 5'd3, 5'd1), 1'b1, 1'b1, 1'b1);
        push(32'h104, mk(5'd4, 5'd3, 5'd1), 32'd12, 32'd5, 5'd4, 1'b1);
        #1 check("t2_stall", bus.o_ready, 1'b0);
        tick();
        check("t2_drained", bus.o_valid, 1'b0);
        check("t2_stall2",  bus.o_ready, 1'b0);
        wb(1'b1, 5'd3, 32'd12);
`ifdef OPERAND_BYPASS_EN
        #1 check("t2_byp_ready", bus.o_ready, 1'b1);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        check("t2_cap_valid", bus.o_valid, 1'b1);
`else
        #1 check("t2_wb_stall", bus.o_ready, 1'b0);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        #1 check("t2_ready_after_wb", bus.o_ready, 1'b1);
        check("t2_not_yet", bus.o_valid, 1'b0);
        tick();
        check("t2_cap_valid", bus.o_valid, 1'b1);
`endif
        check("t2_rs1_12", bus.o_rs1_data, 32'd12);
        check("t2_busy4",  dut.busy[4],    1'b1);
        bus.i_valid = 1'b0;
        wb(1'b1, 5'd4, 32'd7);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        check("t2_busy_clear", dut.busy, 32'h0);

        // 3. Writes x0 and reads x0: no stall, no busy change, rd_wren=0
        drive(32'h108, mk(5'd0, 5'd0, 5'd0), 1'b1, 1'b1, 1'b1);
        push(32'h108, mk(5'd0, 5'd0, 5'd0), 32'd0, 32'd0, 5'd0, 1'b0);
        #1 check("t3_ready", bus.o_ready, 1'b1);
        tick();
        bus.i_valid = 1'b0;
        check("t3_wren", bus.o_rd_wren, 1'b0);
        check("t3_busy", dut.busy,      32'h0);
        tick();

        // 4. Backpressure for 4 cycles with a held instruction
        bus.i_ready = 1'b0;
        drive(32'h10C, mk(5'd6, 5'd1, 5'd2), 1'b0, 1'b0, 1'b1);
        push(32'h10C, mk(5'd6, 5'd1, 5'd2), 32'd5, 32'd7, 5'd6, 1'b1);
        tick();
        drive(32'h110, mk(5'd7, 5'd1, 5'd0), 1'b1, 1'b0, 1'b1);
        push(32'h110, mk(5'd7, 5'd1, 5'd0), 32'd5, 32'd0, 5'd7, 1'b1);
        for (int c = 0; c < 4; c++) begin
            #1;
            check("t4_hold_ready", bus.o_ready,    1'b0);
            check("t4_hold_valid", bus.o_valid,    1'b1);
            check("t4_hold_pc",    bus.o_pc,       32'h10C);
            check("t4_hold_rs1",   bus.o_rs1_data, 32'd5);
            tick();
        end
        bus.i_ready = 1'b1;
        #1 check("t4_accept", bus.o_ready, 1'b1);
        tick();
        check("t4_new_pc", bus.o_pc,    32'h110);
        check("t4_busy67", dut.busy[7:6], 2'b11);

        // 5a. Flush a held ADD x5,x1,x2 without writeback
        drive(32'h114, mk(5'd5, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1);
        push(32'h114, mk(5'd5, 5'd1, 5'd2), 32'd5, 32'd7, 5'd5, 1'b1);
        tick();
        bus.i_ready = 1'b0;
        check("t5_busy5_set", dut.busy[5], 1'b1);
        drive(32'h118, mk(5'd8, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1);
        i_flush = 1'b1;
        #1 check("t5_flush_ready", bus.o_ready, 1'b0);
        tick();
        i_flush = 1'b0;
        bus.i_valid = 1'b0;
        void'(sb_q.pop_front());
        check("t5_valid", bus.o_valid,   1'b0);
        check("t5_busy5", dut.busy[5],   1'b0);
        check("t5_busy8", dut.busy[8],   1'b0);
        check("t5_busy6", dut.busy[6],   1'b1);

        // 5b. Flush a held x5 writer together with a same-cycle writeback of x5
        drive(32'h11C, mk(5'd5, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1);
        push(32'h11C, mk(5'd5, 5'd1, 5'd2), 32'd5, 32'd7, 5'd5, 1'b1);
        tick();
        check("t5b_held", bus.o_valid, 1'b1);
        drive(32'h120, mk(5'd8, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1);
        i_flush = 1'b1;
        wb(1'b1, 5'd5, 32'd99);
        tick();
        i_flush = 1'b0;
        wb(1'b0, 5'd0, 32'd0);
        bus.i_valid = 1'b0;
        void'(sb_q.pop_front());
        check("t5b_valid", bus.o_valid, 1'b0);
        check("t5b_busy5", dut.busy[5], 1'b0);
        check("t5b_busy8", dut.busy[8], 1'b0);

        // 6. Reset with busy bits set and a held instruction
        drive(32'h124, mk(5'd9, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1);
        push(32'h124, mk(5'd9, 5'd1, 5'd2), 32'd5, 32'd7, 5'd9, 1'b1);
        tick();
        check("t6_held",  bus.o_valid, 1'b1);
        check("t6_busy9", dut.busy[9], 1'b1);
        drive(32'h128, mk(5'd10, 5'd1, 5'd2), 1'b1, 1'b1, 1'b1);
        i_reset = 1'b1;
        #1 check("t6_rst_ready", bus.o_ready, 1'b0);
        tick();
        check("t6_valid", bus.o_valid,    1'b0);
        check("t6_pc",    bus.o_pc,       32'h0);
        check("t6_instr", bus.o_instr,    32'h0);
        check("t6_rs1",   bus.o_rs1_data, 32'h0);
        check("t6_rs2",   bus.o_rs2_data, 32'h0);
        check("t6_rd",    bus.o_rd_addr,  5'd0);
        check("t6_wren",  bus.o_rd_wren,  1'b0);
        check("t6_busy",  dut.busy,       32'h0);
        void'(sb_q.pop_front());
        i_reset = 1'b0;
        bus.i_valid = 1'b0;
        tick();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
